// File: rtl/collision_search_engine_if.sv
// Custom-instruction bus plus the word stream to and from the external hash core.
interface collision_search_engine_if #(
  parameter int DIGEST_W = 160
);
  logic                clk_en;
  logic                start;
  logic [1:0]          n;
  logic [31:0]         dataa;
  logic [31:0]         datab;
  logic                done;
  logic [31:0]         result;
  logic                hash_init;
  logic                hash_valid;
  logic [31:0]         hash_data;
  logic                hash_ready;
  logic [DIGEST_W-1:0] hash_digest;

  modport master (
    output clk_en, start, n, dataa, datab, hash_ready, hash_digest,
    input  done, result, hash_init, hash_valid, hash_data
  );

  modport slave (
    input  clk_en, start, n, dataa, datab, hash_ready, hash_digest,
    output done, result, hash_init, hash_valid, hash_data
  );
endinterface

// File: rtl/collision_search_engine.sv
// Proof-of-work style search: streams {counter, message words} into a hash core
// and advances the counter until the digest has the requested leading zeros.
module collision_search_engine #(
  parameter int MSG_WORDS = 16,
  parameter int DIGEST_W  = 160,
  parameter int TARGET_W  = 8
) (
  input logic                      clk,
  input logic                      reset,
  collision_search_engine_if.slave bus
);

  localparam int MSG_W  = 32 * MSG_WORDS;
  localparam int WIDX_W = $clog2(MSG_WORDS);
  localparam int TGT_W  = $clog2(DIGEST_W + 1);

  typedef enum logic [3:0] {
    IDLE, APPEND, CONFIG, LOAD, WAIT, CHECK, STATUS, CLEAR, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         a_q, a_d, b_q, b_d;
  logic [MSG_W-1:0]    msg_q, msg_d;
  logic [7:0]          acnt_q, acnt_d;
  logic [31:0]         ctr_q, ctr_d;
  logic                found_q, found_d, exh_q, exh_d, wrap_q, wrap_d;
  logic [TGT_W-1:0]    tgt_q, tgt_d;
  logic [31:0]         limit_q, limit_d, att_q, att_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [DIGEST_W-1:0] dig_q, dig_d;
  logic [31:0]         res_q, res_d;

  logic                match;
  logic [31:0]         ctr_inc, att_inc, tgt_raw, word_sel;

  // Leading-zero test over the registered digest; target 0 always matches
  always_comb begin
    match = 1'b1;
    for (int unsigned i = 0; i < DIGEST_W; i++) begin
      if (i < 32'(tgt_q) && dig_q[DIGEST_W-1-i]) match = 1'b0;
    end
  end

  // Message word currently addressed by the load index
  always_comb begin
    word_sel = '0;
    for (int unsigned k = 0; k < MSG_WORDS; k++) begin
      if (widx_q == WIDX_W'(k)) word_sel = msg_q[MSG_W-1-32*k -: 32];
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    msg_d   = msg_q;
    acnt_d  = acnt_q;
    ctr_d   = ctr_q;
    found_d = found_q;
    exh_d   = exh_q;
    wrap_d  = wrap_q;
    tgt_d   = tgt_q;
    limit_d = limit_q;
    att_d   = att_q;
    widx_d  = widx_q;
    dig_d   = dig_q;
    res_d   = res_q;
    ctr_inc = ctr_q + 32'd1;
    att_inc = att_q + 32'd1;
    tgt_raw = 32'(a_q[TARGET_W-1:0]);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d = bus.dataa;
          b_d = bus.datab;
          unique case (bus.n)
            2'd0: state_d = APPEND;
            2'd1: state_d = CONFIG;
            2'd2: state_d = STATUS;
            2'd3: state_d = CLEAR;
          endcase
        end
      end
      APPEND: begin
        msg_d        = msg_q << 64;
        msg_d[63:0]  = {a_q, b_q};
        if (acnt_q != 8'hFF) acnt_d = acnt_q + 8'd1;
        res_d   = '0;
        state_d = DONE;
      end
      CLEAR: begin
        msg_d   = '0;
        ctr_d   = a_q;
        found_d = 1'b0;
        exh_d   = 1'b0;
        wrap_d  = 1'b0;
        acnt_d  = '0;
        res_d   = '0;
        state_d = DONE;
      end
      STATUS: begin
        res_d   = {16'b0, acnt_q, 5'b0, wrap_q, exh_q, found_q};
        state_d = DONE;
      end
      CONFIG: begin
        tgt_d   = (tgt_raw > 32'(DIGEST_W)) ? TGT_W'(DIGEST_W) : TGT_W'(tgt_raw);
        limit_d = b_q;
        att_d   = '0;
        found_d = 1'b0;
        exh_d   = 1'b0;
        widx_d  = '0;
        state_d = LOAD;
      end
      LOAD: begin
        if (widx_q == WIDX_W'(MSG_WORDS - 1)) begin
          widx_d  = '0;
          state_d = WAIT;
        end else begin
          widx_d = widx_q + WIDX_W'(1);
        end
      end
      WAIT: begin
        if (bus.hash_ready) begin
          dig_d   = bus.hash_digest;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Counter advances on both hit and miss; wrap is sticky until CLEAR
        ctr_d = ctr_inc;
        if (&ctr_q) wrap_d = 1'b1;
        if (match) begin
          res_d   = ctr_q;
          found_d = 1'b1;
          state_d = DONE;
        end else begin
          att_d = att_inc;
          if (limit_q != '0 && att_inc == limit_q) begin
            exh_d   = 1'b1;
            res_d   = ctr_inc;
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; clk_en freezes everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      msg_q   <= '0;
      acnt_q  <= '0;
      ctr_q   <= '0;
      found_q <= 1'b0;
      exh_q   <= 1'b0;
      wrap_q  <= 1'b0;
      tgt_q   <= '0;
      limit_q <= '0;
      att_q   <= '0;
      widx_q  <= '0;
      dig_q   <= '0;
      res_q   <= '0;
    end else if (bus.clk_en) begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      msg_q   <= msg_d;
      acnt_q  <= acnt_d;
      ctr_q   <= ctr_d;
      found_q <= found_d;
      exh_q   <= exh_d;
      wrap_q  <= wrap_d;
      tgt_q   <= tgt_d;
      limit_q <= limit_d;
      att_q   <= att_d;
      widx_q  <= widx_d;
      dig_q   <= dig_d;
      res_q   <= res_d;
    end
  end

  // Outputs decoded from registered state so reset clears them immediately
  always_comb begin
    bus.done       = (state_q == DONE);
    bus.result     = res_q;
    bus.hash_valid = (state_q == LOAD);
    bus.hash_init  = (state_q == LOAD) && (widx_q == '0);
    bus.hash_data  = '0;
    if (state_q == LOAD) bus.hash_data = (widx_q == '0) ? ctr_q : word_sel;
  end

endmodule

// File: tb/tb_collision_search_engine.sv
// Directed bench for collision_search_engine with a behavioural hash core.
module tb_collision_search_engine;

  localparam int MW = 4;
  localparam int DW = 160;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  collision_search_engine_if #(.DIGEST_W(DW)) bus ();

  collision_search_engine #(
    .MSG_WORDS(MW),
    .DIGEST_W (DW),
    .TARGET_W (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Hash core model: logs every accepted word, digest = {~counter, 0...},
  // ready pulse 3 cycles after the last word of a block.
  logic [31:0] wlog[$];
  int          cd = 0;
  int          sidx = 0;
  logic [31:0] cur_ctr = '0;

  always @(negedge clk) begin
    if (reset) begin
      cd              = 0;
      sidx            = 0;
      bus.hash_ready  = 1'b0;
      bus.hash_digest = '0;
    end else begin
      bus.hash_ready = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.hash_ready  = 1'b1;
          bus.hash_digest = {~cur_ctr, 128'b0};
        end
      end
      if (bus.clk_en && bus.hash_valid) begin
        if (bus.hash_init) begin
          sidx    = 0;
          cur_ctr = bus.hash_data;
        end
        wlog.push_back(bus.hash_data);
        sidx++;
        if (sidx == MW) cd = 3;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from IDLE, wait (bounded) for done, return to IDLE
  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    bus.start = 1'b1;
    bus.n     = op;
    bus.dataa = a;
    bus.datab = b;
    lat       = 0;
    do begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
    end while (!bus.done && lat < 2000);
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_result"}, bus.result, exp_res);
    if (exp_lat > 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  // Start EXECUTE and step until LOAD is presenting word index 2
  task automatic exec_to_word2(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ctr);
    bus.start = 1'b1;
    bus.n     = 2'd1;
    bus.dataa = a;
    bus.datab = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("load0_init", 32'(bus.hash_init), 32'd1);
    chk("load0_data", bus.hash_data, ctr);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    int k;
    reset         = 1'b1;
    bus.clk_en    = 1'b1;
    bus.start     = 1'b0;
    bus.n         = 2'd0;
    bus.dataa     = '0;
    bus.datab     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", bus.result, 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hvalid", 32'(bus.hash_valid), 32'd0);
    chk("rst_hinit", 32'(bus.hash_init), 32'd0);
    chk("rst_hdata", bus.hash_data, 32'd0);
    reset = 1'b0;

    // Message assembly and stream order, target 0
    run("clr0", 2'd3, 32'h0, 32'h0, 32'h0, 2);
    run("app1", 2'd0, 32'h11111111, 32'h22222222, 32'h0, 2);
    run("app2", 2'd0, 32'h33333333, 32'h44444444, 32'h0, 2);
    base = wlog.size();
    run("exec_t0", 2'd1, 32'h0, 32'h0, 32'h0, 0);
    chk("t0_stream_len", 32'(wlog.size() - base), 32'd4);
    chk("t0_w0", wlog[base+0], 32'h00000000);
    chk("t0_w1", wlog[base+1], 32'h22222222);
    chk("t0_w2", wlog[base+2], 32'h33333333);
    chk("t0_w3", wlog[base+3], 32'h44444444);
    run("stat_t0", 2'd2, 32'h0, 32'h0, 32'h00000201, 2);

    // Search with 4 leading zeros, unlimited
    run("clr_a", 2'd3, 32'hEFFFFFFE, 32'h0, 32'h0, 2);
    base = wlog.size();
    run("exec_t4", 2'd1, 32'd4, 32'd0, 32'hF0000000, 0);
    chk("t4_stream_len", 32'(wlog.size() - base), 32'd12);
    chk("t4_third_ctr", wlog[base+8], 32'hF0000000);
    run("stat_t4", 2'd2, 32'h0, 32'h0, 32'h00000001, 2);
    run("stat_t4_again", 2'd2, 32'h0, 32'h0, 32'h00000001, 2);

    // Same search exhausted by a limit of 2
    run("clr_b", 2'd3, 32'hEFFFFFFE, 32'h0, 32'h0, 2);
    base = wlog.size();
    run("exec_lim", 2'd1, 32'd4, 32'd2, 32'hF0000000, 0);
    chk("lim_stream_len", 32'(wlog.size() - base), 32'd8);
    run("stat_lim", 2'd2, 32'h0, 32'h0, 32'h00000002, 2);

    // Counter wrap on a hit
    run("clr_c", 2'd3, 32'hFFFFFFFF, 32'h0, 32'h0, 2);
    run("exec_wrap", 2'd1, 32'd0, 32'd0, 32'hFFFFFFFF, 0);
    run("stat_wrap", 2'd2, 32'h0, 32'h0, 32'h00000005, 2);
    base = wlog.size();
    run("exec_after_wrap", 2'd1, 32'd0, 32'd0, 32'h00000000, 0);
    chk("after_wrap_ctr", wlog[base], 32'h00000000);

    // Target above digest width clamps to the full digest
    run("clr_d", 2'd3, 32'hFFFFFFFD, 32'h0, 32'h0, 2);
    base = wlog.size();
    run("exec_clamp", 2'd1, 32'd200, 32'd0, 32'hFFFFFFFF, 0);
    chk("clamp_stream_len", 32'(wlog.size() - base), 32'd12);
    run("stat_clamp", 2'd2, 32'h0, 32'h0, 32'h00000005, 2);

    // clk_en low for 3 cycles in the middle of LOAD
    run("clr_e", 2'd3, 32'hEFFFFFFE, 32'h0, 32'h0, 2);
    run("app_e1", 2'd0, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'h0, 2);
    run("app_e2", 2'd0, 32'hC2C2C2C2, 32'hD3D3D3D3, 32'h0, 2);
    base = wlog.size();
    exec_to_word2(32'd4, 32'd0, 32'hEFFFFFFE);
    chk("en_w2_data", bus.hash_data, 32'hC2C2C2C2);
    bus.clk_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("en_hold_data", bus.hash_data, 32'hC2C2C2C2);
      chk("en_hold_valid", 32'(bus.hash_valid), 32'd1);
    end
    bus.clk_en = 1'b1;
    k = 0;
    while (!bus.done && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("en_done", 32'(bus.done), 32'd1);
    chk("en_result", bus.result, 32'hF0000000);
    @(posedge clk); #1;
    chk("en_stream_len", 32'(wlog.size() - base), 32'd12);
    chk("en_w0", wlog[base+0], 32'hEFFFFFFE);
    chk("en_w1", wlog[base+1], 32'hB1B1B1B1);
    chk("en_w2", wlog[base+2], 32'hC2C2C2C2);
    chk("en_w3", wlog[base+3], 32'hD3D3D3D3);

    // Asynchronous reset during LOAD word 2
    run("clr_f", 2'd3, 32'h5, 32'h0, 32'h0, 2);
    run("app_f", 2'd0, 32'h1, 32'h2, 32'h0, 2);
    exec_to_word2(32'd4, 32'd0, 32'h5);
    reset = 1'b1;
    #1;
    chk("midrst_hvalid", 32'(bus.hash_valid), 32'd0);
    chk("midrst_hinit", 32'(bus.hash_init), 32'd0);
    chk("midrst_hdata", bus.hash_data, 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run("stat_postrst", 2'd2, 32'h0, 32'h0, 32'h00000000, 2);
    run("app_postrst", 2'd0, 32'h7, 32'h8, 32'h0, 2);
    run("stat_postrst2", 2'd2, 32'h0, 32'h0, 32'h00000100, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/collision_search_engine.md
COLLISION_SEARCH_ENGINE -- requirements
Module: collision_search_engine

Interface
REQ-001 SHALL have parameter MSG_WORDS, default 16, meaning 32-bit words per hash block; must be even and at least 2.
REQ-002 SHALL have parameter DIGEST_W, default 160, meaning hash digest width in bits.
REQ-003 SHALL have parameter TARGET_W, default 8, meaning width of the target field (required leading-zero count).
REQ-004 SHALL have port clk  in  1  meaning the single clock.
REQ-005 SHALL have port reset  in  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port clk_en  in  1  meaning global enable; when low, all registers hold.
REQ-007 SHALL have port start  in  1  meaning custom-instruction start, sampled only in IDLE.
REQ-008 SHALL have port n  in  2  meaning opcode: 0 APPEND, 1 EXECUTE, 2 STATUS, 3 CLEAR.
REQ-009 SHALL have ports dataa and datab  in  32 each  meaning operands.
REQ-010 SHALL have port done  out  1  meaning a one-cycle pulse; result is valid in that cycle.
REQ-011 SHALL have port result  out  32  meaning registered, held until the next done.
REQ-012 SHALL have ports hash_init, hash_valid  out  1 each, and hash_data  out  32, meaning the word stream to the hash core (hash_init marks word 0).
REQ-013 SHALL have ports hash_ready  in  1 and hash_digest  in  DIGEST_W, meaning a digest-valid pulse and its digest.

Function
REQ-014 SHALL use states IDLE, APPEND, CONFIG, LOAD, WAIT, CHECK, STATUS, CLEAR, DONE; all transitions are qualified by clk_en.
REQ-015 SHALL latch n, dataa and datab on the cycle start=1 in IDLE; start in any other state is ignored.
REQ-016 SHALL make APPEND, STATUS and CLEAR take IDLE -> op -> DONE -> IDLE, so done rises 2 cycles after start.
REQ-017 APPEND SHALL shift the message left by 64 bits and insert {dataa,datab} at the low end; word k = bits [32*MSG_WORDS-1-32k -: 32]; append_count increments, saturating at 255; result = 0.
REQ-018 CLEAR SHALL zero the message, set counter to dataa, and clear the found, exhausted and wrapped flags and append_count; result = 0.
REQ-019 STATUS SHALL return {16'b0, append_count[7:0], 5'b0, wrapped, exhausted, found} and SHALL NOT modify any state.
REQ-020 EXECUTE SHALL go IDLE -> CONFIG: target = min(dataa[TARGET_W-1:0], DIGEST_W), limit = datab, attempts = 0, found and exhausted cleared.
REQ-021 LOAD SHALL last exactly MSG_WORDS cycles with hash_valid=1:
- word index 0 drives counter with hash_init=1;
- index i>=1 drives message word i;
- hash_valid and hash_init are 0 in every other state.
REQ-022 WAIT SHALL hold until hash_ready=1 and then enter CHECK; hash_ready in any other state is ignored.
REQ-023 In CHECK, a match means the top target bits of the digest (as registered at hash_ready) are all zero; target=0 always matches.
REQ-024 On a match: result = counter, found = 1, counter increments, then DONE.
REQ-025 On a miss: counter and attempts increment; if limit != 0 and the new attempts == limit, then exhausted = 1 and result = new counter, then DONE; otherwise go to LOAD.
REQ-026 Any counter increment from 0xFFFFFFFF SHALL wrap to 0 and set wrapped.
REQ-027 Counter, message and append_count SHALL persist across instructions until CLEAR or reset.
REQ-028 With clk_en low mid-LOAD, the word index and outputs SHALL hold unchanged.

Reset
REQ-029 On reset, the block SHALL immediately go to IDLE with done=0, result=0, hash_valid=0, hash_init=0, hash_data=0, and all registers, message and flags cleared, even mid-LOAD or mid-WAIT.
REQ-030 After reset deasserts, the block SHALL accept start on the first clk edge.

Verification
Hash model: digest = {~counter, 0...}, hash_ready 3 cycles after the last word; MSG_WORDS=4 unless noted.
REQ-031 CLEAR(0), APPEND(0x11111111,0x22222222), APPEND(0x33333333,0x44444444), EXECUTE(0,0) -> stream 0x00000000,0x22222222,0x33333333,0x44444444; result 0; status 0x00000201.
REQ-032 CLEAR(0xEFFFFFFE), EXECUTE(4,0) -> 3 attempts; result 0xF0000000; found=1.
REQ-033 CLEAR(0xEFFFFFFE), EXECUTE(4,2) -> result 0xF0000000; status = 0x00000002.
REQ-034 CLEAR(0xFFFFFFFF), EXECUTE(0,0) -> result 0xFFFFFFFF; status = 0x00000005; the next stream starts with counter 0.
REQ-035 Assert reset during LOAD word 2 -> outputs zero at once; a following STATUS returns 0; APPEND done 2 cycles after start.
REQ-036 Toggle clk_en low for 3 cycles mid-LOAD -> stream resumes without a skipped or repeated word; same result as REQ-032.
